calc_display_scheduler: RTL and testbench

//   Accepts a signed 8-bit calculator result over a valid/ready handshake, converts its

---
 rtl/calc_display_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_calc_display_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_display_scheduler.sv
// Signed 8-bit result to 3-digit BCD (sequential double-dabble) with a free-running
// 4-digit common-anode scan: ones, tens, hundreds, then sign code.
module calc_display_scheduler #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_value,
    output logic       busy,
    output logic       done,
    output logic [3:0] digit,
    output logic [3:0] an,
    output logic [1:0] state_dbg
);

    // Handshake: a result transfers on the rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, and in_valid outside IDLE is ignored.

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PREP    = 2'd1,
        S_CONVERT = 2'd2,
        S_LOAD    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [7:0]    raw_q, raw_d;
    logic [7:0]    mag_q, mag_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [2:0]    iter_q, iter_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    hund_q, hund_d;
    logic          sign_q, sign_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    digit_q, digit_d;

    logic          accept;
    logic          wrap;
    logic [11:0]   adj;
    logic [19:0]   sh;

    assign accept = in_valid && in_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = S_PREP;
            S_PREP:    state_d = S_CONVERT;
            S_CONVERT: if (iter_q == 3'd7) state_d = S_LOAD;
            S_LOAD:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        if (state_q == S_IDLE) begin
            in_ready = 1'b1;
            busy     = 1'b0;
        end
    end

    assign done      = done_q;
    assign digit     = digit_q;
    assign an        = an_q;
    assign state_dbg = state_q;

    // ---------------- Conversion datapath ----------------
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        sh = {adj, mag_q} << 1;
    end

    // The raw operand is captured on accept and its magnitude taken one cycle later,
    // keeping the abs() adder off the in_value input path.
    always_comb begin
        raw_d  = raw_q;
        mag_d  = mag_q;
        bcd_d  = bcd_q;
        iter_d = iter_q;
        ones_d = ones_q;
        tens_d = tens_q;
        hund_d = hund_q;
        sign_d = sign_q;
        done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) raw_d = in_value;
            end
            S_PREP: begin
                mag_d  = raw_q[7] ? (~raw_q + 8'd1) : raw_q;
                bcd_d  = '0;
                iter_d = '0;
            end
            S_CONVERT: begin
                bcd_d  = sh[19:8];
                mag_d  = sh[7:0];
                iter_d = iter_q + 3'd1;
            end
            S_LOAD: begin
                ones_d = bcd_q[3:0];
                tens_d = bcd_q[7:4];
                hund_d = bcd_q[11:8];
                sign_d = raw_q[7];
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- Display scan ----------------
    // an/digit use the next-cycle index and display values so the output matches
    // the registers in the same cycle they change.
    always_comb begin
        wrap  = (cnt_q == CW'(REFRESH_DIV - 1));
        cnt_d = wrap ? '0 : cnt_q + CW'(1);
        idx_d = wrap ? idx_q + 2'd1 : idx_q;
        an_d    = 4'b1110;
        digit_d = ones_d;
        case (idx_d)
            2'd0: begin an_d = 4'b1110; digit_d = ones_d; end
            2'd1: begin an_d = 4'b1101; digit_d = tens_d; end
            2'd2: begin an_d = 4'b1011; digit_d = hund_d; end
            2'd3: begin an_d = 4'b0111; digit_d = sign_d ? 4'hF : 4'hE; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raw_q   <= '0;
            mag_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            ones_q  <= '0;
            tens_q  <= '0;
            hund_q  <= '0;
            sign_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= 4'b1110;
            digit_q <= 4'h0;
        end else begin
            raw_q   <= raw_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            hund_q  <= hund_d;
            sign_q  <= sign_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            digit_q <= digit_d;
        end
    end

endmodule

// File: tb/tb_calc_display_scheduler.sv
// Bench for calc_display_scheduler: directed steps, expected display words queued on
// accept and checked on done, plus scan checks over full refresh rotations.
module tb_calc_display_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_value = 8'h00;
  logic       in_ready, busy, done;
  logic [3:0] digit, an;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_pass = 0;
  int edge_no = 0;
  int done_cnt = 0;
  int prev_acc = 0;
  bit have_prev = 0;
  bit stream = 0;

  logic [15:0] exp_q[$];
  int          acc_q[$];

  calc_display_scheduler #(.REFRESH_DIV(4)) dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .busy(busy), .done(done), .digit(digit), .an(an),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  // {sign code, hundreds, tens, ones}
  function automatic logic [15:0] model(input logic [7:0] v);
    int s, m;
    s = int'($signed(v));
    m = (s < 0) ? -s : s;
    return {(s < 0) ? 4'hF : 4'hE, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic int idx_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // ---------------- scoreboard monitors ----------------
  always @(posedge clk) begin
    edge_no++;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
    end else if (in_valid && in_ready) begin
      exp_q.push_back(model(in_value));
      acc_q.push_back(edge_no);
      if (stream && have_prev) chk("accept_spacing", edge_no - prev_acc, 11);
      prev_acc = edge_no;
    end
    have_prev = stream && (have_prev || (in_valid && in_ready));
  end

  always @(negedge clk) begin : mon_done
    logic [15:0] e;
    int a, i;
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("latency", edge_no - a, 10);
        chk("ready_with_done", in_ready, 1);
        chk("busy_with_done", busy, 0);
        i = idx_of(an);
        chk("an_onehot_at_done", i >= 0, 1);
        if (i >= 0) chk("digit_at_done", digit, e[4*i +: 4]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] v);
    in_valid = 1'b1;
    in_value = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic scan_check(input logic [15:0] expv);
    int seen[4];
    int i;
    for (int k = 0; k < 4; k++) seen[k] = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      i = idx_of(an);
      chk("scan_an_onehot", i >= 0, 1);
      if (i >= 0) begin
        seen[i]++;
        chk("scan_digit", digit, expv[4*i +: 4]);
      end
    end
    for (int k = 0; k < 4; k++) chk("scan_dwell", seen[k], 4);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [3:0] an_tab[4];
    logic [15:0] zero_word;
    logic [7:0] vals[5];
    int n, dc;
    an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    zero_word = 16'hE000;
    vals = '{8'd123, 8'hF6, 8'h80, 8'h7F, 8'h00};

    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_an", an, 4'b1110);
    chk("rst_digit", digit, 4'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // scan stepping right after reset release
    for (int j = 0; j < 16; j++) begin
      chk("rst_scan_an", an, an_tab[(j / 4) % 4]);
      chk("rst_scan_digit", digit, zero_word[4*((j / 4) % 4) +: 4]);
      @(negedge clk);
    end

    // directed conversions
    for (int k = 0; k < 5; k++) begin
      send(vals[k]);
      wait_done();
      scan_check(model(vals[k]));
    end

    // in_valid held with a different value while busy is ignored
    in_valid = 1'b1;
    in_value = 8'd45;
    @(negedge clk);
    in_value = 8'd99;
    chk("busy_during_convert", busy, 1);
    chk("not_ready_during_convert", in_ready, 0);
    wait_done();
    @(negedge clk);
    in_valid = 1'b0;
    wait_done();
    scan_check(model(8'd99));

    // reset in the middle of a conversion
    send(8'd77);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_an", an, 4'b1110);
    chk("midrst_digit", digit, 4'h0);
    dc = done_cnt;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_done_low", done, 0);
    repeat (20) @(negedge clk);
    chk("midrst_no_done", done_cnt, dc);
    chk("midrst_ready_after", in_ready, 1);
    scan_check(zero_word);

    // continuously valid stream with changing values
    stream = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 70; c++) begin
      in_value = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    in_valid = 1'b0;
    stream = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
